// File: rtl/reg_file_2w4r_pkg.sv
// Shared constants for the dual-write, quad-read register file.
// PC_IDX is the architectural PC slot, which reads back the fetch-supplied PC+8.
package reg_file_2w4r_pkg;

    localparam int D_WIDTH_DEF = 32;
    localparam int RA_WIDTH    = 4;
    localparam logic [RA_WIDTH-1:0] PC_IDX = 4'd15;

    // A write slot only acts when enabled, not aimed at the PC, and out of reset.
    function automatic logic write_qualified(input logic en,
                                             input logic [RA_WIDTH-1:0] addr,
                                             input logic rst_n);
        return en && (addr != PC_IDX) && rst_n;
    endfunction

endpackage

// File: rtl/reg_file_2w4r_read_port.sv
// One read port: R15 / younger-slot bypass / older-slot bypass / stored value,
// resolved combinationally in that priority order.
module rf_read_port
    import reg_file_2w4r_pkg::*;
#(
    parameter int D_WIDTH = D_WIDTH_DEF
) (
    input  logic [RA_WIDTH-1:0] ra,
    input  logic [D_WIDTH-1:0]  r15,
    input  logic                we1,
    input  logic [RA_WIDTH-1:0] wa1,
    input  logic [D_WIDTH-1:0]  wd1,
    input  logic                we2,
    input  logic [RA_WIDTH-1:0] wa2,
    input  logic [D_WIDTH-1:0]  wd2,
    input  logic [D_WIDTH-1:0]  stored,
    output logic [D_WIDTH-1:0]  rd
);

    always_comb begin
        rd = stored;
        if (ra == PC_IDX) begin
            rd = r15;
        end else if (we2 && (wa2 == ra)) begin
            rd = wd2;
        end else if (we1 && (wa1 == ra)) begin
            rd = wd1;
        end
    end

endmodule

// File: rtl/reg_file_2w4r.sv
// Architectural register file: R0-R14 in flops, R15 = PC+8, two write slots
// (slot 2 younger) bypassed onto four combinational read ports.
module reg_file_2w4r
    import reg_file_2w4r_pkg::*;
#(
    parameter int D_WIDTH = D_WIDTH_DEF,
    parameter int NREG    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_RegWrite1W,
    input  logic [RA_WIDTH-1:0] i_WA1W,
    input  logic [D_WIDTH-1:0]  i_Result1W,
    input  logic                i_RegWrite2W,
    input  logic [RA_WIDTH-1:0] i_WA2W,
    input  logic [D_WIDTH-1:0]  i_Result2W,
    input  logic [RA_WIDTH-1:0] i_RA1D,
    input  logic [RA_WIDTH-1:0] i_RA2D,
    input  logic [RA_WIDTH-1:0] i_RA3D,
    input  logic [RA_WIDTH-1:0] i_RA4D,
    input  logic [D_WIDTH-1:0]  i_R15,
    output logic [D_WIDTH-1:0]  o_RD1D,
    output logic [D_WIDTH-1:0]  o_RD2D,
    output logic [D_WIDTH-1:0]  o_RD3D,
    output logic [D_WIDTH-1:0]  o_RD4D
);

    // No handshake: a write is accepted every cycle and reads are always valid.
    logic [D_WIDTH-1:0]  regs [NREG-1];
    logic                we1, we2;
    logic [RA_WIDTH-1:0] ra     [4];
    logic [D_WIDTH-1:0]  stored [4];
    logic [D_WIDTH-1:0]  rd     [4];

    assign we1 = write_qualified(i_RegWrite1W, i_WA1W, rst_n);
    assign we2 = write_qualified(i_RegWrite2W, i_WA2W, rst_n);

    // Slot 2 is applied last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG - 1; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (we1) regs[i_WA1W] <= i_Result1W;
            if (we2) regs[i_WA2W] <= i_Result2W;
        end
    end

    assign ra[0] = i_RA1D;
    assign ra[1] = i_RA2D;
    assign ra[2] = i_RA3D;
    assign ra[3] = i_RA4D;

    for (genvar p = 0; p < 4; p++) begin : g_port
        // The PC slot has no flop; its stored value is never selected.
        assign stored[p] = (ra[p] == PC_IDX) ? '0 : regs[ra[p]];

        rf_read_port #(.D_WIDTH(D_WIDTH)) u_port (
            .ra     (ra[p]),
            .r15    (i_R15),
            .we1    (we1),
            .wa1    (i_WA1W),
            .wd1    (i_Result1W),
            .we2    (we2),
            .wa2    (i_WA2W),
            .wd2    (i_Result2W),
            .stored (stored[p]),
            .rd     (rd[p])
        );
    end

    assign o_RD1D = rd[0];
    assign o_RD2D = rd[1];
    assign o_RD3D = rd[2];
    assign o_RD4D = rd[3];

endmodule

// File: tb/tb_reg_file_2w4r.sv
// Self-checking bench for reg_file_2w4r: directed scenarios plus randomized
// traffic against an array-based register model.
module tb_reg_file_2w4r;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         we1, we2;
    logic [3:0]   wa1, wa2;
    logic [W-1:0] wd1, wd2;
    logic [3:0]   ra [4];
    logic [W-1:0] r15;
    logic [W-1:0] rd1, rd2, rd3, rd4;

    logic [W-1:0] model [15];
    logic [W-1:0] exp_q [$];
    int checks   = 0;
    int failures = 0;

    reg_file_2w4r dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_RegWrite1W (we1),
        .i_WA1W       (wa1),
        .i_Result1W   (wd1),
        .i_RegWrite2W (we2),
        .i_WA2W       (wa2),
        .i_Result2W   (wd2),
        .i_RA1D       (ra[0]),
        .i_RA2D       (ra[1]),
        .i_RA3D       (ra[2]),
        .i_RA4D       (ra[3]),
        .i_R15        (r15),
        .o_RD1D       (rd1),
        .o_RD2D       (rd2),
        .o_RD3D       (rd3),
        .o_RD4D       (rd4)
    );

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference read: PC, then the younger write, then the older write, then the register.
    function automatic logic [W-1:0] model_read(input logic [3:0] a);
        if (a == 4'd15) return r15;
        if (rst_n && we2 && wa2 == a) return wd2;
        if (rst_n && we1 && wa1 == a) return wd1;
        return model[a];
    endfunction

    task automatic model_commit();
        if (!rst_n) begin
            for (int i = 0; i < 15; i++) model[i] = '0;
        end else begin
            if (we1 && wa1 != 4'd15) model[wa1] = wd1;
            if (we2 && wa2 != 4'd15) model[wa2] = wd2;
        end
    endtask

    // Drives are set just after a rising edge; outputs are sampled 4ns later.
    task automatic step(input string tag, input bit do_check);
        logic [W-1:0] obs [4];
        #4;
        if (do_check) begin
            for (int p = 0; p < 4; p++) exp_q.push_back(model_read(ra[p]));
            obs[0] = rd1; obs[1] = rd2; obs[2] = rd3; obs[3] = rd4;
            for (int p = 0; p < 4; p++) begin
                check_val($sformatf("%s_p%0d_a%0d", tag, p + 1, ra[p]), obs[p], exp_q.pop_front());
            end
        end
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic drive_idle();
        we1 = 1'b0; we2 = 1'b0;
        wa1 = '0;   wa2 = '0;
        wd1 = '0;   wd2 = '0;
    endtask

    task automatic drive_reads(input logic [3:0] a0, input logic [3:0] a1,
                               input logic [3:0] a2, input logic [3:0] a3);
        ra[0] = a0; ra[1] = a1; ra[2] = a2; ra[3] = a3;
    endtask

    initial begin
        for (int i = 0; i < 15; i++) model[i] = '0;
        rst_n = 1'b0;
        drive_idle();
        drive_reads(4'd3, 4'd3, 4'd3, 4'd3);
        r15 = 32'h0000_1008;

        // Reset held two cycles while a write to R3 is presented.
        we1 = 1'b1; wa1 = 4'd3; wd1 = 32'h0000_DEAD;
        step("rst_hold0", 1'b0);
        step("rst_hold1", 1'b1);
        rst_n = 1'b1;
        drive_idle();
        for (int a = 0; a < 16; a += 4) begin
            drive_reads(4'(a), 4'(a + 1), 4'(a + 2), 4'(a + 3));
            step("after_rst", 1'b1);
        end
        check_val("after_rst_r3", model[3], 32'h0);

        // Single write with same-cycle bypass, then storage readback.
        we1 = 1'b1; wa1 = 4'd5; wd1 = 32'h1234_5678;
        drive_reads(4'd5, 4'd0, 4'd1, 4'd2);
        step("wr_bypass", 1'b1);
        drive_idle();
        drive_reads(4'd0, 4'd1, 4'd5, 4'd2);
        step("wr_stored", 1'b1);

        // Same-address collision: the younger slot wins.
        we1 = 1'b1; wa1 = 4'd7; wd1 = 32'h11;
        we2 = 1'b1; wa2 = 4'd7; wd2 = 32'h22;
        drive_reads(4'd7, 4'd7, 4'd7, 4'd7);
        step("collide_byp", 1'b1);
        drive_idle();
        step("collide_st", 1'b1);

        // Writes to R15 are dropped; R15 always follows the PC+8 input.
        we1 = 1'b1; wa1 = 4'd15; wd1 = 32'hFFFF;
        we2 = 1'b1; wa2 = 4'd15; wd2 = 32'hFFFF;
        r15 = 32'h1008;
        drive_reads(4'd15, 4'd15, 4'd15, 4'd15);
        step("r15_a", 1'b1);
        drive_idle();
        r15 = 32'h2000;
        step("r15_b", 1'b1);

        // Two independent writes seen on all four ports.
        we1 = 1'b1; wa1 = 4'd1; wd1 = 32'hA;
        we2 = 1'b1; wa2 = 4'd2; wd2 = 32'hB;
        drive_reads(4'd1, 4'd2, 4'd1, 4'd2);
        step("dual_byp", 1'b1);
        drive_idle();
        step("dual_st", 1'b1);

        // Reset mid-stream: the write in the reset cycle is neither bypassed nor kept.
        we1 = 1'b1; wa1 = 4'd9; wd1 = 32'h55;
        drive_reads(4'd9, 4'd9, 4'd9, 4'd9);
        step("mid_load", 1'b1);
        rst_n = 1'b0;
        wd1 = 32'h66;
        step("mid_rst", 1'b1);
        rst_n = 1'b1;
        drive_idle();
        step("mid_after", 1'b1);

        // Randomized traffic with occasional reset and biased collisions.
        for (int n = 0; n < 500; n++) begin
            rst_n = ($urandom_range(0, 24) != 0);
            we1 = $urandom_range(0, 1);
            we2 = $urandom_range(0, 1);
            wa1 = 4'($urandom_range(0, 15));
            wa2 = ($urandom_range(0, 3) == 0) ? wa1 : 4'($urandom_range(0, 15));
            wd1 = $urandom;
            wd2 = $urandom;
            r15 = $urandom;
            for (int p = 0; p < 4; p++) begin
                ra[p] = ($urandom_range(0, 2) == 0) ? (p[0] ? wa2 : wa1) : 4'($urandom_range(0, 15));
            end
            step("rand", 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
